// File: rtl/lfsr_pkg.sv
// Shared FSM state type and maximal-length Fibonacci tap masks for the
// LFSR word generator and its shift-register core.
package lfsr_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } gen_state_e;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with feedback XOR, seed load and shift enable.
// Latency: state updates on the edge after shift/load; fb is combinational from state.
// Backpressure: none, the caller gates shift; load wins over shift.
module lfsr_core #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             fb
);

    logic [WIDTH-1:0] state;

    assign fb = ^(state & TAPS);

    // A zero seed would lock the register up, so it is replaced by SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (seed_in == '0) ? SEED : seed_in;
        end else if (shift) begin
            state <= {state[WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_word_gen.sv
// Assembles OUT_BITS successive LFSR feedback bits into a word behind a valid/ready handshake.
// Latency: word valid OUT_BITS enabled cycles after FILL entry; one word per OUT_BITS+1 cycles.
// Backpressure: while rnd_ready is low in HOLD the LFSR and word are frozen.
module lfsr_word_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = TAPS_16,
    parameter logic [WIDTH-1:0] SEED     = 16'h0001,
    parameter int unsigned      OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [OUT_BITS-1:0] rnd_word,
    output logic                rnd_valid,
    input  logic                rnd_ready
);

    localparam int unsigned     CW       = $clog2(OUT_BITS + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(OUT_BITS - 1);

    gen_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OUT_BITS-1:0] word_q, word_d;
    logic [OUT_BITS-1:0] word_shifted;
    logic                shift;
    logic                fb;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (shift),
        .load    (load),
        .seed_in (seed_in),
        .fb      (fb)
    );

    generate
        if (OUT_BITS == 1) begin : g_one_bit
            assign word_shifted = fb;
        end else begin : g_multi_bit
            assign word_shifted = {word_q[OUT_BITS-2:0], fb};
        end
    endgenerate

    // The word and LFSR shift in lockstep, so the low OUT_BITS of the LFSR
    // state always mirror the word once it is complete.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        shift   = 1'b0;
        if (load) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            word_d  = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (en) begin
                        shift  = 1'b1;
                        word_d = word_shifted;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rnd_ready) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    assign rnd_valid = (state_q == ST_HOLD);
    assign rnd_word  = word_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Scoreboard bench for lfsr_word_gen at WIDTH=16, TAPS=16'hB400, SEED=1, OUT_BITS=8.
module tb_lfsr_word_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        rnd_ready = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic [7:0]  rnd_word;
    logic        rnd_valid;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          zero_seen = 1'b0;
    logic [15:0] model_state = 16'h0001;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    lfsr_word_gen #(
        .WIDTH    (16),
        .TAPS     (16'hB400),
        .SEED     (16'h0001),
        .OUT_BITS (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .seed_in   (seed_in),
        .rnd_word  (rnd_word),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (dut.u_core.state == 16'h0000) zero_seen = 1'b1;
    endtask

    // Reference generator: eight Fibonacci steps produce one expected word.
    task automatic push_word();
        logic [7:0] w;
        logic       fbit;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            fbit        = ^(model_state & 16'hB400);
            model_state = {model_state[14:0], fbit};
            w           = {w[6:0], fbit};
        end
        exp_q.push_back(w);
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic wait_valid(input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max) begin
            tick();
            n++;
            if (rnd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load = 1'b0;
        en = 1'b0;
        rnd_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        model_state = 16'h0001;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rnd_valid); end
        n_tests++;
        if (rnd_word !== 8'h00) begin n_fail++; $display("FAIL reset_word: got %h, expected 00", rnd_word); end
        n_tests++;
        if (dut.u_core.state !== 16'h0001) begin n_fail++; $display("FAIL reset_state: got %h, expected 0001", dut.u_core.state); end
    endtask

    task automatic test_first_words();
        int n; bit ok; logic [7:0] e;
        do_reset();
        en = 1'b1;
        rnd_ready = 1'b1;
        push_word();
        push_word();
        wait_valid(20, n, ok);
        n_tests++;
        if (!ok || n != 8) begin n_fail++; $display("FAIL first_latency: got %0d cycles (ok=%0b), expected 8", n, ok); end
        e = pop_exp();
        n_tests++;
        if (rnd_word !== e) begin n_fail++; $display("FAIL first_word: got %h, expected %h", rnd_word, e); end
        wait_valid(20, n, ok);
        n_tests++;
        if (!ok || n != 9) begin n_fail++; $display("FAIL second_latency: got %0d cycles (ok=%0b), expected 9", n, ok); end
        e = pop_exp();
        n_tests++;
        if (rnd_word !== e || rnd_word !== 8'h2D) begin n_fail++; $display("FAIL second_word: got %h, expected %h (2D)", rnd_word, e); end
        n_tests++;
        if (dut.u_core.state !== 16'h002D) begin n_fail++; $display("FAIL second_state: got %h, expected 002d", dut.u_core.state); end
    endtask

    task automatic test_backpressure();
        int n; bit ok; bit moved; logic [7:0] e, w0; logic [15:0] s0;
        do_reset();
        en = 1'b1;
        push_word();
        wait_valid(20, n, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || rnd_word !== e) begin n_fail++; $display("FAIL bp_word: got %h (ok=%0b), expected %h", rnd_word, ok, e); end
        w0 = rnd_word;
        s0 = dut.u_core.state;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rnd_valid !== 1'b1 || rnd_word !== w0 || dut.u_core.state !== s0) moved = 1'b1;
        end
        n_tests++;
        if (moved) begin n_fail++; $display("FAIL bp_hold_stable: got word %h state %h, expected word %h state %h", rnd_word, dut.u_core.state, w0, s0); end
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        n_tests++;
        if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_transfer: valid got %b, expected 0", rnd_valid); end
        push_word();
        wait_valid(20, n, ok);
        n_tests++;
        if (!ok || n != 8) begin n_fail++; $display("FAIL bp_next_latency: got %0d cycles, expected 8", n); end
        e = pop_exp();
        n_tests++;
        if (rnd_word !== e) begin n_fail++; $display("FAIL bp_next_word: got %h, expected %h", rnd_word, e); end
    endtask

    task automatic test_en_pause();
        int n; bit ok; logic [7:0] e; logic [15:0] s0;
        do_reset();
        en = 1'b1;
        rnd_ready = 1'b1;
        push_word();
        push_word();
        wait_valid(20, n, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || rnd_word !== e) begin n_fail++; $display("FAIL pause_first_word: got %h (ok=%0b), expected %h", rnd_word, ok, e); end
        for (int i = 0; i < 4; i++) tick();
        en = 1'b0;
        s0 = dut.u_core.state;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (dut.u_core.state !== s0 || rnd_valid !== 1'b0) begin n_fail++; $display("FAIL pause_frozen: got state %h valid %b, expected state %h valid 0", dut.u_core.state, rnd_valid, s0); end
        en = 1'b1;
        wait_valid(20, n, ok);
        n_tests++;
        if (!ok || n != 5) begin n_fail++; $display("FAIL pause_latency: got %0d remaining cycles, expected 5", n); end
        e = pop_exp();
        n_tests++;
        if (rnd_word !== e) begin n_fail++; $display("FAIL pause_word: got %h, expected %h", rnd_word, e); end
    endtask

    task automatic test_load();
        int n; bit ok; logic [7:0] e;
        do_reset();
        en = 1'b1;
        push_word();
        wait_valid(20, n, ok);
        e = pop_exp();
        load = 1'b1;
        seed_in = 16'h0000;
        tick();
        load = 1'b0;
        n_tests++;
        if (rnd_valid !== 1'b0 || rnd_word !== 8'h00) begin n_fail++; $display("FAIL load_hold_drop: got valid %b word %h, expected 0 00", rnd_valid, rnd_word); end
        n_tests++;
        if (dut.u_core.state !== 16'h0001) begin n_fail++; $display("FAIL load_zero_seed: got %h, expected 0001", dut.u_core.state); end
        model_state = 16'h0001;
        push_word();
        wait_valid(20, n, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || n != 8 || rnd_word !== e) begin n_fail++; $display("FAIL load_zero_word: got %h after %0d cycles, expected %h after 8", rnd_word, n, e); end
        rnd_ready = 1'b1;
        load = 1'b1;
        seed_in = 16'hACE1;
        tick();
        load = 1'b0;
        n_tests++;
        if (dut.u_core.state !== 16'hACE1 || rnd_valid !== 1'b0) begin n_fail++; $display("FAIL load_with_transfer: got state %h valid %b, expected ace1 0", dut.u_core.state, rnd_valid); end
        model_state = 16'hACE1;
        push_word();
        wait_valid(20, n, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || n != 8 || rnd_word !== e) begin n_fail++; $display("FAIL load_seed_word: got %h after %0d cycles, expected %h after 8", rnd_word, n, e); end
    endtask

    task automatic test_async_reset();
        int n; bit ok; logic [7:0] e;
        do_reset();
        en = 1'b1;
        push_word();
        wait_valid(20, n, ok);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rnd_valid !== 1'b0 || rnd_word !== 8'h00) begin n_fail++; $display("FAIL async_reset: got valid %b word %h, expected 0 00", rnd_valid, rnd_word); end
        tick();
        tick();
        exp_q.delete();
        model_state = 16'h0001;
        rst_n = 1'b1;
        rnd_ready = 1'b1;
        push_word();
        push_word();
        wait_valid(20, n, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || n != 8 || rnd_word !== e) begin n_fail++; $display("FAIL async_first_word: got %h after %0d cycles, expected %h after 8", rnd_word, n, e); end
        wait_valid(20, n, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || n != 9 || rnd_word !== e || dut.u_core.state !== 16'h002D) begin n_fail++; $display("FAIL async_second_word: got %h state %h after %0d cycles, expected %h state 002d after 9", rnd_word, dut.u_core.state, n, e); end
    endtask

    task automatic test_free_run();
        int n; bit ok; int bad_word; int bad_inv; logic [7:0] e;
        do_reset();
        en = 1'b1;
        rnd_ready = 1'b1;
        zero_seen = 1'b0;
        bad_word = 0;
        bad_inv = 0;
        ok = 1'b1;
        for (int w = 0; w < 8191; w++) begin
            push_word();
            wait_valid(20, n, ok);
            if (!ok) break;
            e = pop_exp();
            if (rnd_word !== e) bad_word++;
            if (rnd_word !== dut.u_core.state[7:0]) bad_inv++;
        end
        n_tests++;
        if (!ok || bad_word != 0) begin n_fail++; $display("FAIL free_words: got %0d wrong words (ok=%0b), expected 0", bad_word, ok); end
        n_tests++;
        if (bad_inv != 0) begin n_fail++; $display("FAIL free_invariant: got %0d holds with word != state[7:0], expected 0", bad_inv); end
        for (int i = 0; i < 8; i++) tick();
        n_tests++;
        if (dut.u_core.state !== 16'h0001) begin n_fail++; $display("FAIL free_period: got state %h after 65535 steps, expected 0001", dut.u_core.state); end
        n_tests++;
        if (zero_seen) begin n_fail++; $display("FAIL free_nonzero: got all-zero state, expected never zero"); end
    endtask

    initial begin
        test_reset();
        test_first_words();
        test_backpressure();
        test_en_pause();
        test_load();
        test_async_reset();
        test_free_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
